// File: rtl/alu_opnd_stage.sv
// ALU operand-conditioning stage: decodes invert/carry controls from the instruction and
// holds conditioned operands in a valid/ready register with optional two-entry skid buffer.
module alu_opnd_stage #(
  parameter int DATA_W = 16,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_cin,
  output logic              out_inva,
  output logic              out_invb,
  output logic [1:0]        occupancy
);

  // state    | meaning
  // ST_EMPTY | no entry held
  // ST_BUSY  | main register holds the head entry
  // ST_FULL  | main holds head, skid holds the next entry; input stalled
  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              inva;
    logic              invb;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   dec_inva, dec_invb, dec_cin;
  logic   in_fire;

  always_comb begin
    dec_inva = 1'b0;
    dec_invb = 1'b0;
    dec_cin  = 1'b0;
    if (instr[15:11] == 5'b01011) begin
      dec_invb = 1'b1;
    end else if (instr[15:11] == 5'b11011 && instr[1:0] == 2'b11) begin
      dec_invb = 1'b1;
    end else if (instr[15:11] == 5'b11011 && instr[1:0] == 2'b01) begin
      dec_inva = 1'b1;
      dec_cin  = 1'b1;
    end else if (instr[15:11] == 5'b01001) begin
      dec_inva = 1'b1;
      dec_cin  = 1'b1;
    end else if (instr[15:11] == 5'b11100 || instr[15:11] == 5'b11101 ||
                 instr[15:11] == 5'b11110) begin
      dec_invb = 1'b1;
      dec_cin  = 1'b1;
    end
  end

  always_comb begin
    in_entry.instr = instr;
    in_entry.a     = dec_inva ? ~op_a : op_a;
    in_entry.b     = dec_invb ? ~op_b : op_b;
    in_entry.cin   = dec_cin;
    in_entry.inva  = dec_inva;
    in_entry.invb  = dec_invb;
  end

  assign out_valid = (state_q != ST_EMPTY);
  // Without a skid entry, a full stage can only accept when the head leaves this cycle.
  assign in_ready  = SKID ? (state_q != ST_FULL) : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_ready) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_instr = main_q.instr;
  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_cin   = main_q.cin;
  assign out_inva  = main_q.inva;
  assign out_invb  = main_q.invb;

endmodule

// File: tb/tb_alu_opnd_stage.sv
// Scoreboard bench for alu_opnd_stage: SKID=1 instance checked through a queue/monitor,
// plus a SKID=0 instance checked directly for its combinational in_ready.
module tb_alu_opnd_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        cin;
    logic        inva;
    logic        invb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] instr, op_a, op_b, out_instr, out_a, out_b;
  logic        out_cin, out_inva, out_invb;
  logic [1:0]  occupancy;

  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [15:0] instr0, op_a0, op_b0, out_instr0, out_a0, out_b0;
  logic        out_cin0, out_inva0, out_invb0;
  logic [1:0]  occupancy0;

  alu_opnd_stage #(.DATA_W(16), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_a(out_a), .out_b(out_b), .out_cin(out_cin),
    .out_inva(out_inva), .out_invb(out_invb), .occupancy(occupancy)
  );

  alu_opnd_stage #(.DATA_W(16), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .instr(instr0),
    .op_a(op_a0), .op_b(op_b0), .flush(1'b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_instr(out_instr0), .out_a(out_a0), .out_b(out_b0), .out_cin(out_cin0),
    .out_inva(out_inva0), .out_invb(out_invb0), .occupancy(occupancy0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  vec_t sb[$];
  int   pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t vec(int i);
    vec_t v;
    case (i)
      0: v = '{16'hD801, 16'h0005, 16'h0003, 16'hFFFA, 16'h0003, 1'b1, 1'b1, 1'b0}; // SUB
      1: v = '{16'h5800, 16'h00F0, 16'h0F0F, 16'h00F0, 16'hF0F0, 1'b0, 1'b0, 1'b1}; // ANDNI
      2: v = '{16'hF000, 16'h1234, 16'h00FF, 16'h1234, 16'hFF00, 1'b1, 1'b0, 1'b1}; // 11110
      3: v = '{16'hF800, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0}; // SCO
      4: v = '{16'hD800, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0}; // ADD
      5: v = '{16'hD803, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1}; // ANDN
      6: v = '{16'h4800, 16'h0001, 16'h0000, 16'hFFFE, 16'h0000, 1'b1, 1'b1, 1'b0}; // SUBI
      7: v = '{16'hE000, 16'h0F0F, 16'h8000, 16'h0F0F, 16'h7FFF, 1'b1, 1'b0, 1'b1}; // SEQ
      8: v = '{16'hE802, 16'h0000, 16'h0001, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 1'b1}; // SLT
      default: v = '{16'hD802, 16'h0003, 16'h0004, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready hold at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vec_t e;
      if (sb.size() == 0) begin
        check("unexpected_output", {48'd0, out_instr}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        check("head_entry", {13'd0, out_instr, out_a, out_b, out_cin, out_inva, out_invb},
              {13'd0, e.instr, e.ea, e.eb, e.cin, e.inva, e.invb});
      end
    end
  end

  task automatic push(input int idx);
    vec_t v;
    int n;
    v = vec(idx);
    n = 0;
    in_valid = 1'b1;
    instr = v.instr;
    op_a = v.a_in;
    op_b = v.b_in;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'd0, 64'd1);
    end else begin
      sb.push_back(v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; instr = '0; op_a = '0; op_b = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; instr0 = '0; op_a0 = '0; op_b0 = '0; out_ready0 = 1'b0;
    #3;
    check("reset_state", {44'd0, occupancy, out_valid, in_ready, out_a},
          {44'd0, 2'd0, 1'b0, 1'b1, 16'h0000});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // streaming all decode patterns, one per cycle, with latency check on the first
    out_ready = 1'b1;
    push(0);
    check("latency_1", {62'd0, out_valid, occupancy == 2'd1}, 64'h3);
    for (int i = 1; i < 10; i++) push(i);
    drain("stream_drain");

    // backpressure: two held, third stalled upstream, then in-order consecutive pops
    out_ready = 1'b0;
    pop_cyc.delete();
    push(0);
    push(1);
    check("full_occ_rdy", {61'd0, occupancy, in_ready}, {61'd0, 2'd2, 1'b0});
    fork
      push(2);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("held_upstream", {45'd0, occupancy, in_ready, out_a}, {45'd0, 2'd2, 1'b0, 16'hFFFA});
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_pop_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check("bp_consecutive", {32'(pop_cyc[1] - pop_cyc[0]), 32'(pop_cyc[2] - pop_cyc[1])},
            {32'd1, 32'd1});
    end

    // flush with simultaneous input: both the held entry and the input are dropped
    out_ready = 1'b0;
    push(3);
    check("pre_flush_occ", 64'(occupancy), 64'd1);
    in_valid = 1'b1; instr = 16'hD801; op_a = 16'h0005; op_b = 16'h0003; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    sb.delete();
    check("flush_state", {61'd0, out_valid, occupancy, in_ready}, {61'd0, 1'b0, 2'd0, 1'b1});
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_input_lost", 64'(out_valid), 64'd0);
    push(5);
    drain("post_flush_drain");

    // asynchronous reset while FULL
    out_ready = 1'b0;
    push(6);
    push(7);
    check("pre_rst_full", 64'(occupancy), 64'd2);
    rst = 1'b1;
    #2;
    check("async_rst", {44'd0, out_valid, occupancy, in_ready, out_a},
          {44'd0, 1'b0, 2'd0, 1'b1, 16'h0000});
    #1 rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_empty", 64'(out_valid), 64'd0);

    // SKID=0 instance: single entry, in_ready follows out_ready combinationally
    in_valid0 = 1'b1; instr0 = 16'hD801; op_a0 = 16'h0005; op_b0 = 16'h0003;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    check("s0_load", {11'd0, out_valid0, occupancy0, in_ready0, out_instr0, out_a0, out_b0,
          out_cin0, out_inva0, out_invb0},
          {11'd0, 1'b1, 2'd1, 1'b0, 16'hD801, 16'hFFFA, 16'h0003, 1'b1, 1'b1, 1'b0});
    out_ready0 = 1'b1;
    #1;
    check("s0_rdy_follow_hi", 64'(in_ready0), 64'd1);
    out_ready0 = 1'b0;
    #1;
    check("s0_rdy_follow_lo", 64'(in_ready0), 64'd0);
    in_valid0 = 1'b1; instr0 = 16'h5800; op_a0 = 16'h00F0; op_b0 = 16'h0F0F;
    @(posedge clk);
    #1;
    check("s0_stalled", {47'd0, occupancy0, out_a0}, {47'd0, 2'd1, 16'hFFFA});
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    check("s0_replace", {14'd0, occupancy0, out_instr0, out_a0, out_b0},
          {14'd0, 2'd1, 16'h5800, 16'h00F0, 16'hF0F0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
